cc_arb: RTL
===========

CC_ARB -- requirements
Module: cc_arb

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing the decoder; fixed at 4.
REQ-002 Parameter: OPW, 4, opcode width driven to the decoder select inputs.
REQ-003 Parameter: HOLD, 2, cycles the decoder enable is held per grant; legal range 1..15.
REQ-004 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: req  input  4  per-requester request level; bit n belongs to requester n.
REQ-007 Port: op  input  16  packed opcodes; op[4n+3:4n] belongs to requester n.
REQ-008 Port: dec_res  input  20  result vector returned by the shared decoder.
REQ-009 Port: dec_en  output  1  decoder enable strobe.
REQ-010 Port: dec_op  output  4  opcode presented to the decoder select lines.
REQ-011 Port: gnt  output  4  one-hot grant; all-zero when idle.
REQ-012 Port: ack  output  4  one-cycle completion pulse to the granted requester.
REQ-013 Port: res  output  20  captured decoder result, held until the next capture.
REQ-014 Port: abrt  output  1  one-cycle pulse on an aborted transaction.
REQ-015 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-016 All outputs shall be registered.
REQ-017 The FSM shall have states IDLE, ISSUE and ACK.
REQ-018 In IDLE with req nonzero, the winner shall be the first set bit of req, searching upward from pointer ptr (2 bits) with wrap 3->0.
REQ-019 On the IDLE->ISSUE edge, the block shall set gnt to one-hot(winner), dec_op to op[winner], dec_en to 1, and hold counter cnt to HOLD-1.
REQ-020 In ISSUE with req[winner] high and cnt nonzero, cnt shall decrement and dec_op, gnt and dec_en shall hold.
REQ-021 In ISSUE with req[winner] high and cnt zero, the block shall capture res<=dec_res, clear dec_en, assert ack[winner] and enter ACK; dec_en is therefore high for exactly HOLD cycles.
REQ-022 In ACK, the block shall clear ack and gnt, set ptr to winner+1 mod 4, and enter IDLE; IDLE shall last at least one cycle before the next grant.
REQ-023 If req[winner] is low in ISSUE, the transaction shall abort: dec_en, gnt and ack shall be 0, res shall be unchanged, abrt shall pulse for one cycle, ptr shall become winner+1 mod 4, and the next state shall be IDLE.
REQ-024 Requests arriving during ISSUE or ACK shall wait; op of non-granted requesters shall be ignored.
REQ-025 op[winner] changing during ISSUE shall not affect dec_op.
REQ-026 Latency shall be: req sampled high in IDLE at edge k gives gnt and dec_en high after edge k, and ack high after edge k+HOLD.
REQ-027 A requester holding req high through ack shall lose priority to any other pending requester (round-robin fairness).
REQ-028 busy shall be 0 exactly when the state is IDLE.

Reset
REQ-029 While rst_n is low, the block shall force state IDLE, ptr=0, cnt=0, gnt=0, ack=0, dec_en=0, dec_op=0, res=0, abrt=0 and busy=0, regardless of clk.
REQ-030 Assertion of rst_n mid-transaction shall drop dec_en, gnt and ack immediately, with no ack or abrt pulse.
REQ-031 After rst_n deasserts, the first grant shall follow the rule in REQ-018 with ptr=0.

Verification
REQ-032 Bench: reset, then req=0001, op[3:0]=1010, HOLD=2, dec_res=0xABCDE -> gnt=0001 and dec_op=1010 for 3 cycles, dec_en high 2 cycles, ack=0001 for one cycle, res=0xABCDE.
REQ-033 Bench: req=1111 held continuously -> grant order 0,1,2,3,0, with one idle cycle between grants.
REQ-034 Bench: ptr=2, req=0011 -> gnt=0001, then gnt=0010.
REQ-035 Bench: grant to requester 1, then req[1] dropped in the first ISSUE cycle -> abrt pulse, no ack, res unchanged, next winner searched from requester 2.
REQ-036 Bench: rst_n pulled low while dec_en=1 -> all outputs 0 asynchronously; after release, req=1000 gives gnt=1000.
REQ-037 Bench: HOLD=1 and HOLD=15 -> dec_en width 1 and 15 cycles respectively; ack always one cycle.

Source files
------------

// File: rtl/cc_arb.sv
// cc_arb: round-robin arbiter sharing one decoder among four requesters.
// A grant drives the winner's opcode to the decoder for HOLD cycles. The
// decoder result is then captured and acknowledged with a one-cycle pulse.
// Dropping the request mid-issue aborts the transaction. The pointer always
// moves past the last winner, so a requester that keeps its request high
// yields to any other requester that is waiting.
module cc_arb #(
   parameter int NREQ = 4,
   parameter int OPW  = 4,
   parameter int HOLD = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ*OPW-1:0] op,
   input  logic [19:0]         dec_res,
   output logic                dec_en,
   output logic [OPW-1:0]      dec_op,
   output logic [NREQ-1:0]     gnt,
   output logic [NREQ-1:0]     ack,
   output logic [19:0]         res,
   output logic                abrt,
   output logic                busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      ACK   = 2'd2
   } state_t;

   state_t     state;
   logic [1:0] ptr;       // first requester searched in IDLE
   logic [1:0] win;       // requester owning the current transaction
   logic [3:0] cnt;       // remaining issue cycles after the current one
   logic [1:0] pick;
   logic       pick_vld;
   logic [1:0] idx;

   // Round-robin search: lowest offset from ptr with a pending request wins.
   // The loop runs from the largest offset down, so the nearest hit is written last.
   always_comb begin
      pick     = ptr;
      pick_vld = 1'b0;
      idx      = ptr;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (req[idx]) begin
            pick     = idx;
            pick_vld = 1'b1;
         end
      end
   end

   // Transaction FSM. Every output is a register updated here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ptr    <= '0;
         win    <= '0;
         cnt    <= '0;
         gnt    <= '0;
         ack    <= '0;
         dec_en <= 1'b0;
         dec_op <= '0;
         res    <= '0;
         abrt   <= 1'b0;
         busy   <= 1'b0;
      end else begin
         // ack and abrt are single-cycle pulses unless re-asserted below
         ack  <= '0;
         abrt <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  win    <= pick;
                  gnt    <= NREQ'(1) << pick;
                  dec_op <= op[pick*OPW +: OPW];
                  dec_en <= 1'b1;
                  cnt    <= 4'(HOLD - 1);
                  busy   <= 1'b1;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               if (!req[win]) begin
                  // requester withdrew: drop everything, keep res, skip past it
                  dec_en <= 1'b0;
                  gnt    <= '0;
                  abrt   <= 1'b1;
                  ptr    <= win + 2'd1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end else if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  res      <= dec_res;
                  dec_en   <= 1'b0;
                  ack[win] <= 1'b1;
                  state    <= ACK;
               end
            end
            ACK: begin
               gnt   <= '0;
               ptr   <= win + 2'd1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               gnt    <= '0;
               dec_en <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
